// File: rtl/uart_rx_oversampled_pkg.sv
// Shared definitions for the oversampled UART receiver: FSM states,
// default line parameters and divisor/width helpers.
package uart_rx_oversampled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 19_200;

    // Sample-tick divisor, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

    // Counter width that stays at least one bit for tiny ranges.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_baud_tick.sv
// Free-running sample-tick generator: one tick every DIV clocks.
module uart_baud_tick
    import uart_rx_oversampled_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned W   = $clog2(DIV + 1);

    logic [W-1:0] cnt_q;

    // Divider counter, wraps DIV-1 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == W'(DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == W'(DIV - 1));

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with oversampled mid-bit sampling, start-bit glitch
// rejection and framing-error / break handling.
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    localparam int unsigned S_W = cnt_width(OVERSAMPLE);
    localparam int unsigned N_W = cnt_width(DATA_BITS);

    logic                 tick;
    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q;
    logic [S_W-1:0]       s_q;
    logic [N_W-1:0]       n_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 done_q;
    logic                 ferr_q;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous line, idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], i_Rx};
        end
    end

    assign rx_s = sync_q[1];

    // Frame FSM with registered byte output and one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (tick && !rx_s) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s_q == S_W'(OVERSAMPLE / 2 - 1)) begin
                            s_q <= '0;
                            n_q <= '0;
                            state_q <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s_q == S_W'(OVERSAMPLE - 1)) begin
                            s_q     <= '0;
                            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                            if (n_q == N_W'(DATA_BITS - 1)) begin
                                state_q <= ST_STOP;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s_q == S_W'(OVERSAMPLE - 1)) begin
                            s_q <= '0;
                            if (rx_s) begin
                                dout_q  <= shreg_q;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= ST_BREAK;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    // Not tick-gated: leave as soon as the line returns high.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: fast-parameter instance for
// framing, glitch, break, back-to-back and reset cases, plus a default-
// parameter instance driven with skewed baud rates.
module tb_uart_rx_oversampled;
    import uart_rx_oversampled_pkg::*;

    localparam int unsigned BIT_A     = 16;
    localparam int unsigned BIT_B_NOM = 2608;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] dout_a;
    logic [7:0] dout_b;
    logic       done_a;
    logic       ferr_a;
    logic       done_b;
    logic       ferr_b;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    int unsigned done_a_cnt = 0;
    int unsigned ferr_a_cnt = 0;
    int unsigned done_b_cnt = 0;
    int unsigned ferr_b_cnt = 0;
    int unsigned both_cnt   = 0;
    int unsigned done_a_cyc = 0;
    int unsigned start_cyc  = 0;
    logic [7:0]  rxq[$];

    uart_rx_oversampled #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .i_Rx         (rx_a),
        .dout         (dout_a),
        .rx_done_tick (done_a),
        .frame_err    (ferr_a)
    );

    uart_rx_oversampled dut_b (
        .clk          (clk),
        .rst          (rst),
        .i_Rx         (rx_b),
        .dout         (dout_b),
        .rx_done_tick (done_b),
        .frame_err    (ferr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (done_a) begin
            done_a_cnt <= done_a_cnt + 1;
            done_a_cyc <= cyc;
            rxq.push_back(dout_a);
        end
        if (ferr_a) ferr_a_cnt <= ferr_a_cnt + 1;
        if (done_b) done_b_cnt <= done_b_cnt + 1;
        if (ferr_b) ferr_b_cnt <= ferr_b_cnt + 1;
        if ((done_a && ferr_a) || (done_b && ferr_b)) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_a(input int unsigned n);
        rx_a = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_a(input logic v, input int unsigned n);
        rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        bit_a(1'b0, BIT_A);
        for (int i = 0; i < 8; i++) bit_a(b[i], BIT_A);
        bit_a(stop, BIT_A);
    endtask

    task automatic bit_b(input logic v, input int unsigned n);
        rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] b, input int unsigned bitlen);
        bit_b(1'b0, bitlen);
        for (int i = 0; i < 8; i++) bit_b(b[i], bitlen);
        bit_b(1'b1, bitlen);
        bit_b(1'b1, 2 * bitlen);
    endtask

    int unsigned d0;
    int unsigned f0;
    int unsigned lat;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout_a), 32'h00);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_ferr", 32'(ferr_a), 32'h0);
        rst = 1'b0;
        idle_a(20);

        // 1: single frame 0x55 with latency check
        d0 = done_a_cnt; f0 = ferr_a_cnt;
        send_a(8'h55, 1'b1);
        idle_a(16);
        lat = done_a_cyc - start_cyc;
        check("t1_done_cnt", done_a_cnt - d0, 1);
        check("t1_dout", 32'(dout_a), 32'h55);
        check("t1_latency", (lat >= 149 && lat <= 155) ? 152 : lat, 152);
        check("t1_no_ferr", ferr_a_cnt - f0, 0);

        // 2: 4-clk start glitch rejected, then 0xA3
        d0 = done_a_cnt; f0 = ferr_a_cnt;
        bit_a(1'b0, 4);
        idle_a(40);
        check("t2_glitch_done", done_a_cnt - d0, 0);
        check("t2_glitch_ferr", ferr_a_cnt - f0, 0);
        check("t2_idle_state", 32'(dut_a.state_q), 32'(ST_IDLE));
        send_a(8'hA3, 1'b1);
        idle_a(16);
        check("t2_dout", 32'(dout_a), 32'hA3);
        check("t2_done_cnt", done_a_cnt - d0, 1);

        // 3: framing error then long break, then 0x5A
        d0 = done_a_cnt; f0 = ferr_a_cnt;
        send_a(8'h7E, 1'b0);
        bit_a(1'b0, 20 * BIT_A);
        check("t3_dout_in_break", 32'(dout_a), 32'hA3);
        bit_a(1'b0, 20 * BIT_A);
        idle_a(32);
        check("t3_ferr_cnt", ferr_a_cnt - f0, 1);
        check("t3_no_done", done_a_cnt - d0, 0);
        check("t3_dout_kept", 32'(dout_a), 32'hA3);
        send_a(8'h5A, 1'b1);
        idle_a(16);
        check("t3_dout_after", 32'(dout_a), 32'h5A);
        check("t3_done_cnt", done_a_cnt - d0, 1);

        // 4: back-to-back frames, no idle gap
        d0 = done_a_cnt;
        rxq.delete();
        send_a(8'h00, 1'b1);
        send_a(8'hFF, 1'b1);
        send_a(8'h81, 1'b1);
        idle_a(16);
        check("t4_done_cnt", done_a_cnt - d0, 3);
        check("t4_byte0", (rxq.size() > 0) ? 32'(rxq[0]) : 32'hDEAD, 32'h00);
        check("t4_byte1", (rxq.size() > 1) ? 32'(rxq[1]) : 32'hDEAD, 32'hFF);
        check("t4_byte2", (rxq.size() > 2) ? 32'(rxq[2]) : 32'hDEAD, 32'h81);

        // 5: async reset during data bit 3 of 0xC4
        f0 = ferr_a_cnt;
        bit_a(1'b0, BIT_A);
        bit_a(1'b0, BIT_A);   // bit0 of 0xC4
        bit_a(1'b0, BIT_A);   // bit1
        bit_a(1'b1, BIT_A);   // bit2
        bit_a(1'b0, 8);       // middle of bit3
        #2 rst = 1'b1;
        #1;
        check("t5_rst_dout", 32'(dout_a), 32'h00);
        check("t5_rst_done", 32'(done_a), 32'h0);
        check("t5_rst_ferr", 32'(ferr_a), 32'h0);
        @(negedge clk);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_a(20);
        d0 = done_a_cnt;
        send_a(8'h3C, 1'b1);
        idle_a(16);
        check("t5_dout", 32'(dout_a), 32'h3C);
        check("t5_done_cnt", done_a_cnt - d0, 1);
        check("t5_no_ferr", ferr_a_cnt - f0, 0);

        // 6: default parameters with +2% and -2% baud skew
        d0 = done_b_cnt;
        send_b(8'h96, (BIT_B_NOM * 102) / 100);
        check("t6_slow_done", done_b_cnt - d0, 1);
        check("t6_slow_dout", 32'(dout_b), 32'h96);
        d0 = done_b_cnt;
        send_b(8'h69, (BIT_B_NOM * 98) / 100);
        check("t6_fast_done", done_b_cnt - d0, 1);
        check("t6_fast_dout", 32'(dout_b), 32'h69);
        check("t6_no_ferr", ferr_b_cnt, 0);

        check("strobes_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
